// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions used by the interconnect blocks: channel opcodes
// and the helper mapping a transfer size and low address bits to byte lanes.
package tlul_pkg;

    typedef enum logic [2:0] {
        PUT_FULL_DATA    = 3'd0,
        PUT_PARTIAL_DATA = 3'd1,
        GET              = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1
    } tl_d_op_e;

    // Byte lanes touched by a naturally aligned transfer on a 32-bit bus.
    // Sizes above a word yield no lanes; callers flag those as errors.
    function automatic logic [3:0] size_lane_mask(input logic [2:0] size,
                                                  input logic [1:0] addr_lo);
        logic [3:0] lanes;
        case (size)
            3'd0:    lanes = 4'b0001 << addr_lo;
            3'd1:    lanes = 4'b0011 << addr_lo;
            3'd2:    lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/tlul_req_check.sv
// Combinational legality check of a Channel A request: opcode, address
// window, size, alignment and mask consistency; also yields the word index.
module tlul_req_check
    import tlul_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    MASK_WIDTH   = 4,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    MEM_DEPTH    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                    IDX_WIDTH    = $clog2(MEM_DEPTH)
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [SIZE_WIDTH-1:0]   size,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [MASK_WIDTH-1:0]   mask,
    output logic                    err,
    output logic [IDX_WIDTH-1:0]    word_idx
);

    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(MEM_DEPTH) << 2;

    logic [ADDR_WIDTH-1:0] offset;
    logic [MASK_WIDTH-1:0] lane_mask;
    logic                  in_range;
    logic                  size_ok;
    logic                  aligned;
    logic                  op_ok;

    always_comb begin
        offset    = address - BASE_ADDR;
        // The lower bound check keeps a wrapped subtraction out of the window.
        in_range  = (address >= BASE_ADDR) && ({1'b0, offset} < SPAN);
        size_ok   = (size <= SIZE_WIDTH'(2));
        lane_mask = size_lane_mask(size, address[1:0]);

        case (size)
            SIZE_WIDTH'(1): aligned = ~address[0];
            SIZE_WIDTH'(2): aligned = (address[1:0] == 2'b00);
            default:        aligned = 1'b1;
        endcase

        case (opcode)
            PUT_FULL_DATA:    op_ok = (mask == lane_mask);
            PUT_PARTIAL_DATA: op_ok = (mask != '0) && ((mask & ~lane_mask) == '0);
            GET:              op_ok = 1'b1;
            default:          op_ok = 1'b0;
        endcase

        err      = !(in_range && size_ok && aligned && op_ok);
        word_idx = offset[IDX_WIDTH+1:2];
    end

endmodule

// File: rtl/tlul_mem_responder.sv
// TL-UL slave endpoint: word memory behind a single registered Channel D
// response slot. Note: `reset` is active low and asynchronous.
module tlul_mem_responder
    import tlul_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int                    SIZE_WIDTH   = 3,
    parameter int                    SRC_WIDTH    = 1,
    parameter int                    SINK_WIDTH   = 1,
    parameter int                    OPCODE_WIDTH = 3,
    parameter int                    PARAM_WIDTH  = 3,
    parameter int                    MEM_DEPTH    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic [SRC_WIDTH-1:0]    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic [SRC_WIDTH-1:0]    d_source,
    output logic [SINK_WIDTH-1:0]   d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error,
    output logic [15:0]             err_count
);

    localparam int IDX_WIDTH = $clog2(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  req_err;
    logic [IDX_WIDTH-1:0]  word_idx;
    logic                  accept;
    logic                  is_get;
    logic                  is_put;
    logic                  unused_param;

    assign unused_param = ^a_param;

    tlul_req_check #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .MASK_WIDTH  (MASK_WIDTH),
        .SIZE_WIDTH  (SIZE_WIDTH),
        .OPCODE_WIDTH(OPCODE_WIDTH),
        .MEM_DEPTH   (MEM_DEPTH),
        .BASE_ADDR   (BASE_ADDR),
        .IDX_WIDTH   (IDX_WIDTH)
    ) u_req_check (
        .opcode  (a_opcode),
        .size    (a_size),
        .address (a_address),
        .mask    (a_mask),
        .err     (req_err),
        .word_idx(word_idx)
    );

    // Handshake: a beat moves on a channel at a rising edge where valid and
    // ready are both high. Channel A is ready whenever the single D slot is
    // empty or is being drained at that same edge, so the slot never overflows.
    assign a_ready = !d_valid || d_ready;
    assign accept  = a_valid && a_ready && reset;
    assign is_get  = (a_opcode == GET);
    assign is_put  = (a_opcode == PUT_FULL_DATA) || (a_opcode == PUT_PARTIAL_DATA);

    // Memory is deliberately left out of reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && !req_err && is_put) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (a_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= a_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d_valid  <= 1'b0;
            d_opcode <= '0;
            d_param  <= '0;
            d_size   <= '0;
            d_source <= '0;
            d_sink   <= '0;
            d_data   <= '0;
            d_error  <= 1'b0;
        end else if (accept) begin
            d_valid  <= 1'b1;
            d_opcode <= is_get ? OPCODE_WIDTH'(ACCESS_ACK_DATA) : OPCODE_WIDTH'(ACCESS_ACK);
            d_param  <= '0;
            d_size   <= a_size;
            d_source <= a_source;
            d_sink   <= '0;
            d_data   <= (is_get && !req_err) ? mem[word_idx] : '0;
            d_error  <= req_err;
        end else if (d_ready) begin
            d_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (accept && req_err && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_tlul_mem_responder.sv
// Directed bench for tlul_mem_responder: Put/Get data path, error cases,
// streaming, backpressure, error counter saturation and mid-flight reset.
module tb_tlul_mem_responder;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [0:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [2:0]  d_size;
    logic [0:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic [15:0] err_count;

    int checks;
    int failures;

    logic [31:0] vals [4];

    tlul_mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_opcode (a_opcode),
        .a_param  (a_param),
        .a_size   (a_size),
        .a_source (a_source),
        .a_address(a_address),
        .a_mask   (a_mask),
        .a_data   (a_data),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .d_opcode (d_opcode),
        .d_param  (d_param),
        .d_size   (d_size),
        .d_source (d_source),
        .d_sink   (d_sink),
        .d_data   (d_data),
        .d_error  (d_error),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One request with d_ready high; returns the response seen just after the accept edge.
    task automatic do_req(input logic [2:0] op, input logic [2:0] sz, input logic src,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                          output logic r_valid, output logic [2:0] r_op, output logic [31:0] r_data,
                          output logic r_err, output logic r_src, output logic [2:0] r_size);
        int waited;
        @(negedge clk);
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_valid   = 1'b1;
        d_ready   = 1'b1;
        waited    = 0;
        while (a_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 20) begin
            $display("FAIL req_accept_timeout a_ready=%b required=1", a_ready);
            failures++;
        end
        @(posedge clk);
        #1;
        r_valid = d_valid;
        r_op    = d_opcode;
        r_data  = d_data;
        r_err   = d_error;
        r_src   = d_source;
        r_size  = d_size;
        a_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (d_valid !== 1'b0 || d_opcode !== 3'd0 || d_data !== 32'h0 || d_error !== 1'b0
            || d_param !== 3'd0 || d_size !== 3'd0 || d_source !== 1'b0 || d_sink !== 1'b0) begin
            $display("FAIL reset_d_outputs valid=%b op=%0d data=%h err=%b got nonzero, required all 0",
                     d_valid, d_opcode, d_data, d_error);
            failures++;
        end
        checks++;
        if (err_count !== 16'h0) begin
            $display("FAIL reset_err_count got=%h required=0000", err_count);
            failures++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
            $display("FAIL reset_release a_ready=%b d_valid=%b required 1/0", a_ready, d_valid);
            failures++;
        end
    endtask

    task automatic test_put_get();
        logic v, e, s;
        logic [2:0] op, sz;
        logic [31:0] dat;
        do_req(3'd0, 3'd2, 1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF, v, op, dat, e, s, sz);
        checks++;
        if (v !== 1'b1 || op !== 3'd0 || e !== 1'b0) begin
            $display("FAIL put_full_ack valid=%b op=%0d err=%b required 1/0/0", v, op, e);
            failures++;
        end
        do_req(3'd4, 3'd2, 1'b1, 32'h10, 4'hF, 32'h0, v, op, dat, e, s, sz);
        checks++;
        if (v !== 1'b1 || op !== 3'd1 || e !== 1'b0 || dat !== 32'hDEAD_BEEF) begin
            $display("FAIL get_after_put valid=%b op=%0d err=%b data=%h required 1/1/0/deadbeef",
                     v, op, e, dat);
            failures++;
        end
        checks++;
        if (s !== 1'b1 || sz !== 3'd2) begin
            $display("FAIL get_echo source=%b size=%0d required 1/2", s, sz);
            failures++;
        end
    endtask

    task automatic test_partial();
        logic v, e, s;
        logic [2:0] op, sz;
        logic [31:0] dat;
        do_req(3'd1, 3'd0, 1'b0, 32'h12, 4'b0100, 32'h00AA_0000, v, op, dat, e, s, sz);
        checks++;
        if (v !== 1'b1 || op !== 3'd0 || e !== 1'b0 || sz !== 3'd0) begin
            $display("FAIL put_partial_ack valid=%b op=%0d err=%b size=%0d required 1/0/0/0",
                     v, op, e, sz);
            failures++;
        end
        do_req(3'd4, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0, v, op, dat, e, s, sz);
        checks++;
        if (dat !== 32'hDEAA_BEEF || e !== 1'b0) begin
            $display("FAIL get_after_partial data=%h err=%b required deaabeef/0", dat, e);
            failures++;
        end
    endtask

    task automatic test_errors();
        logic v, e, s;
        logic [2:0] op, sz;
        logic [31:0] dat;
        logic [2:0]  e_opc  [5] = '{3'd4, 3'd4, 3'd3, 3'd0, 3'd1};
        logic [2:0]  e_size [5] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd0};
        logic [31:0] e_addr [5] = '{32'h400, 32'h2, 32'h10, 32'h10, 32'h10};
        logic [3:0]  e_mask [5] = '{4'hF, 4'hF, 4'hF, 4'h3, 4'h0};
        logic [2:0]  e_rop  [5] = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd0};
        for (int i = 0; i < 5; i++) begin
            do_req(e_opc[i], e_size[i], 1'b1, e_addr[i], e_mask[i], 32'hFFFF_FFFF,
                   v, op, dat, e, s, sz);
            checks++;
            if (v !== 1'b1 || e !== 1'b1 || dat !== 32'h0 || op !== e_rop[i] || s !== 1'b1) begin
                $display("FAIL error_resp_%0d valid=%b err=%b data=%h op=%0d src=%b required 1/1/0/%0d/1",
                         i, v, e, dat, op, s, e_rop[i]);
                failures++;
            end
        end
        checks++;
        if (err_count !== 16'd5) begin
            $display("FAIL error_count got=%0d required=5", err_count);
            failures++;
        end
        do_req(3'd4, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0, v, op, dat, e, s, sz);
        checks++;
        if (dat !== 32'hDEAA_BEEF || e !== 1'b0) begin
            $display("FAIL mem_unchanged_after_errors data=%h err=%b required deaabeef/0", dat, e);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        logic v, e, s;
        logic [2:0] op, sz;
        logic [31:0] dat;
        logic [31:0] exp_q [$];
        logic [31:0] exp_word;
        for (int k = 0; k < 4; k++) begin
            do_req(3'd0, 3'd2, 1'b0, 32'h20 + 32'(4*k), 4'hF, vals[k], v, op, dat, e, s, sz);
        end
        do_req(3'd0, 3'd2, 1'b0, 32'h3FC, 4'hF, 32'h1234_5678, v, op, dat, e, s, sz);
        do_req(3'd4, 3'd2, 1'b0, 32'h3FC, 4'hF, 32'h0, v, op, dat, e, s, sz);
        checks++;
        if (dat !== 32'h1234_5678 || e !== 1'b0) begin
            $display("FAIL last_word data=%h err=%b required 12345678/0", dat, e);
            failures++;
        end
        @(negedge clk);
        a_valid  = 1'b1;
        d_ready  = 1'b1;
        a_opcode = 3'd4;
        a_size   = 3'd2;
        a_mask   = 4'hF;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            a_address = 32'h20 + 32'(4*k);
            a_source  = 1'(k);
            exp_q.push_back(vals[k]);
            @(posedge clk);
            #1;
            exp_word = exp_q.pop_front();
            checks++;
            if (d_valid !== 1'b1 || d_data !== exp_word || d_source !== 1'(k)) begin
                $display("FAIL stream_get_%0d valid=%b data=%h src=%b required 1/%h/%0d",
                         k, d_valid, d_data, d_source, exp_word, k % 2);
                failures++;
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        d_ready   = 1'b0;
        a_valid   = 1'b1;
        a_opcode  = 3'd4;
        a_size    = 3'd2;
        a_mask    = 4'hF;
        a_source  = 1'b0;
        a_address = 32'h20;
        @(posedge clk);
        #1;
        checks++;
        if (d_valid !== 1'b1 || d_data !== vals[0]) begin
            $display("FAIL bp_first valid=%b data=%h required 1/%h", d_valid, d_data, vals[0]);
            failures++;
        end
        @(negedge clk);
        a_address = 32'h24;
        a_source  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (a_ready !== 1'b0) begin
                $display("FAIL bp_a_ready_%0d got=%b required=0", i, a_ready);
                failures++;
            end
            checks++;
            if (d_valid !== 1'b1 || d_data !== vals[0] || d_source !== 1'b0 || d_opcode !== 3'd1) begin
                $display("FAIL bp_hold_%0d valid=%b data=%h src=%b op=%0d required 1/%h/0/1",
                         i, d_valid, d_data, d_source, d_opcode, vals[0]);
                failures++;
            end
        end
        @(negedge clk);
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (d_valid !== 1'b1 || d_data !== vals[1] || d_source !== 1'b1) begin
            $display("FAIL bp_release valid=%b data=%h src=%b required 1/%h/1",
                     d_valid, d_data, d_source, vals[1]);
            failures++;
        end
        @(negedge clk);
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (d_valid !== 1'b0) begin
            $display("FAIL bp_drain valid=%b required=0", d_valid);
            failures++;
        end
    endtask

    task automatic test_err_saturate();
        @(negedge clk);
        a_valid   = 1'b1;
        d_ready   = 1'b1;
        a_opcode  = 3'd3;
        a_size    = 3'd2;
        a_address = 32'h10;
        a_mask    = 4'hF;
        repeat (65529) @(posedge clk);
        #1;
        checks++;
        if (err_count !== 16'hFFFE) begin
            $display("FAIL err_count_near_sat got=%h required=fffe", err_count);
            failures++;
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (err_count !== 16'hFFFF) begin
            $display("FAIL err_count_saturated got=%h required=ffff", err_count);
            failures++;
        end
        checks++;
        if (d_error !== 1'b1 || d_data !== 32'h0 || d_opcode !== 3'd0) begin
            $display("FAIL sat_resp err=%b data=%h op=%0d required 1/0/0", d_error, d_data, d_opcode);
            failures++;
        end
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic v, e, s;
        logic [2:0] op, sz;
        logic [31:0] dat;
        @(negedge clk);
        d_ready   = 1'b0;
        a_valid   = 1'b1;
        a_opcode  = 3'd4;
        a_size    = 3'd2;
        a_address = 32'h10;
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        checks++;
        if (d_valid !== 1'b1) begin
            $display("FAIL rst_mid_pending valid=%b required=1", d_valid);
            failures++;
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (d_valid !== 1'b0 || err_count !== 16'h0 || d_data !== 32'h0) begin
            $display("FAIL rst_mid_async valid=%b err_count=%h data=%h required 0/0000/0",
                     d_valid, err_count, d_data);
            failures++;
        end
        repeat (2) @(negedge clk);
        reset   = 1'b1;
        d_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
            $display("FAIL rst_mid_release a_ready=%b valid=%b required 1/0", a_ready, d_valid);
            failures++;
        end
        do_req(3'd4, 3'd2, 1'b0, 32'h10, 4'hF, 32'h0, v, op, dat, e, s, sz);
        checks++;
        if (dat !== 32'hDEAA_BEEF || e !== 1'b0) begin
            $display("FAIL mem_kept_over_reset data=%h err=%b required deaabeef/0", dat, e);
            failures++;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        vals[0]   = 32'h1111_2222;
        vals[1]   = 32'h3333_4444;
        vals[2]   = 32'h5555_6666;
        vals[3]   = 32'h7777_8888;
        reset     = 1'b0;
        a_valid   = 1'b0;
        a_opcode  = 3'd0;
        a_param   = 3'd0;
        a_size    = 3'd0;
        a_source  = 1'b0;
        a_address = 32'h0;
        a_mask    = 4'h0;
        a_data    = 32'h0;
        d_ready   = 1'b0;

        test_reset();
        test_put_get();
        test_partial();
        test_errors();
        test_back_to_back();
        test_backpressure();
        test_err_saturate();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
